// File: rtl/mul_pkg.sv
// Shared encodings for the sequential multiplier: MulType select codes, FSM states and
// the operation decode used by mul_seq and by downstream decode logic.
package mul_pkg;

    localparam logic [1:0] MulTypeMul   = 2'b00;
    localparam logic [1:0] MulTypeUmull = 2'b01;
    localparam logic [1:0] MulTypeSmull = 2'b10;

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StBusy = 2'b01;
    localparam logic [1:0] StDone = 2'b10;

    typedef enum logic [1:0] {
        OpMul,
        OpUmull,
        OpSmull
    } mul_op_e;

    // The reserved encoding behaves as a plain low-word multiply.
    function automatic mul_op_e mul_op_decode(input logic [1:0] mul_type);
        case (mul_type)
            MulTypeUmull: return OpUmull;
            MulTypeSmull: return OpSmull;
            default:      return OpMul;
        endcase
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier: MUL / UMULL / SMULL, one iteration per cycle,
// with registered results and {N,Z} flags held until the next completion.
module mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       MulType,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags
);

    localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

    logic [1:0]         r_state;
    logic [CntW-1:0]    r_cnt;
    mul_op_e            r_op;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_res_lo;
    logic [WIDTH-1:0]   r_res_hi;
    logic [1:0]         r_flags;

    mul_op_e            w_op_in;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_fixed;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_hi;
    logic               w_n;
    logic               w_z;

    // Magnitudes fit in WIDTH bits unsigned, so the most-negative operand needs no extra bit.
    always_comb begin
        w_op_in = mul_op_decode(MulType);
        w_a_neg = (w_op_in == OpSmull) && SrcA[WIDTH-1];
        w_b_neg = (w_op_in == OpSmull) && SrcB[WIDTH-1];
        w_a_mag = w_a_neg ? -SrcA : SrcA;
        w_b_mag = w_b_neg ? -SrcB : SrcB;
    end

    // Upper half accumulates; multiplier bits shift out of the lower half.
    always_comb begin
        w_addend = r_prod[0] ? r_mcand : '0;
        w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    end

    always_comb begin
        w_fixed = r_neg ? -r_prod : r_prod;
        w_lo    = w_fixed[WIDTH-1:0];
        w_hi    = (r_op == OpMul) ? '0 : w_fixed[2*WIDTH-1:WIDTH];
        w_n     = (r_op == OpMul) ? w_lo[WIDTH-1] : w_hi[WIDTH-1];
        w_z     = (w_lo == '0) && (w_hi == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_op     <= OpMul;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (Start) begin
                        r_state <= StBusy;
                        r_cnt   <= '0;
                        r_op    <= w_op_in;
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_mcand <= w_a_mag;
                        r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
                    end
                end
                StBusy: begin
                    if (r_cnt == CntLast) begin
                        r_state  <= StDone;
                        r_res_lo <= w_lo;
                        r_res_hi <= w_hi;
                        r_flags  <= {w_n, w_z};
                    end else begin
                        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign Busy     = (r_state == StBusy) || (r_state == StDone);
    assign Done     = (r_state == StDone);
    assign ResultLo = r_res_lo;
    assign ResultHi = r_res_hi;
    assign MulFlags = r_flags;

endmodule
